// File: rtl/vga_scan_if.sv
// Scan-timer bundle: pixel in from the generator,
// sync, position and pixel out toward the DAC and generator.
interface vga_scan_if;
  logic [15:0] pixelValue;
  logic        hSync;
  logic        fSync;
  logic [15:0] pixleOutput;
  logic [9:0]  xPos;
  logic [9:0]  yPos;
  logic [9:0]  xPosAhead;
  logic        activeVideo;
  logic        frameStart;
  logic        flash;

  modport master (
    input  pixelValue,
    output hSync,
    output fSync,
    output pixleOutput,
    output xPos,
    output yPos,
    output xPosAhead,
    output activeVideo,
    output frameStart,
    output flash
  );

  modport slave (
    output pixelValue,
    input  hSync,
    input  fSync,
    input  pixleOutput,
    input  xPos,
    input  yPos,
    input  xPosAhead,
    input  activeVideo,
    input  frameStart,
    input  flash
  );
endinterface

// File: rtl/vga_scan_timer.sv
// VGA raster counters, registered sync/pixel output stage,
// frame strobe and text flash phase.
module vga_scan_timer #(
  parameter int H_ACTIVE     = 640,
  parameter int H_FP         = 16,
  parameter int H_SYNC       = 96,
  parameter int H_BP         = 48,
  parameter int V_ACTIVE     = 480,
  parameter int V_FP         = 10,
  parameter int V_SYNC       = 2,
  parameter int V_BP         = 33,
  parameter int PREFETCH     = 1,
  parameter int FLASH_FRAMES = 16
) (
  input  logic        clkVGA,
  input  logic        rst_n,
  vga_scan_if.master  vga
);

  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS_START = H_ACTIVE + H_FP;
  localparam int HS_END   = HS_START + H_SYNC;
  localparam int VS_START = V_ACTIVE + V_FP;
  localparam int VS_END   = VS_START + V_SYNC;
  localparam int FW =
    (FLASH_FRAMES > 1) ? $clog2(FLASH_FRAMES) : 1;

  logic [9:0]    h_cnt;
  logic [9:0]    v_cnt;
  logic [FW-1:0] flash_cnt;
  logic          flash_q;
  logic          h_last;
  logic          v_last;
  logic          frame_wrap;
  logic          h_in_sync;
  logic          v_in_sync;
  logic          in_active;
  logic          h_sync_q;
  logic          f_sync_q;
  logic          active_q;
  logic          start_q;
  logic [15:0]   pix_q;
  logic [10:0]   ahead_sum;
  logic [9:0]    ahead;

  assign h_last     = (h_cnt == 10'(H_TOTAL - 1));
  assign v_last     = (v_cnt == 10'(V_TOTAL - 1));
  assign frame_wrap = h_last && v_last;

  assign h_in_sync = (h_cnt >= 10'(HS_START)) &&
                     (h_cnt <  10'(HS_END));
  assign v_in_sync = (v_cnt >= 10'(VS_START)) &&
                     (v_cnt <  10'(VS_END));
  assign in_active = (h_cnt < 10'(H_ACTIVE)) &&
                     (v_cnt < 10'(V_ACTIVE));

  always_ff @(posedge clkVGA or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_last) begin
      h_cnt <= '0;
      v_cnt <= v_last ? '0 : v_cnt + 10'd1;
    end else begin
      h_cnt <= h_cnt + 10'd1;
    end
  end

  // Flash phase flips on the wrap that completes every
  // FLASH_FRAMES-th frame.
  always_ff @(posedge clkVGA or negedge rst_n) begin
    if (!rst_n) begin
      flash_cnt <= '0;
      flash_q   <= 1'b0;
    end else if (frame_wrap) begin
      if (flash_cnt == FW'(FLASH_FRAMES - 1)) begin
        flash_cnt <= '0;
        flash_q   <= ~flash_q;
      end else begin
        flash_cnt <= flash_cnt + FW'(1);
      end
    end
  end

  // One pipeline stage: everything here reflects the
  // counters as they stood before the edge.
  always_ff @(posedge clkVGA or negedge rst_n) begin
    if (!rst_n) begin
      h_sync_q <= 1'b1;
      f_sync_q <= 1'b1;
      active_q <= 1'b0;
      start_q  <= 1'b0;
      pix_q    <= '0;
    end else begin
      h_sync_q <= ~h_in_sync;
      f_sync_q <= ~v_in_sync;
      active_q <= in_active;
      start_q  <= (h_cnt == '0) && (v_cnt == '0);
      pix_q    <= in_active ? vga.pixelValue : '0;
    end
  end

  assign ahead_sum = {1'b0, h_cnt} + 11'(PREFETCH);

  always_comb begin
    ahead = ahead_sum[9:0];
    if (ahead_sum >= 11'(H_TOTAL))
      ahead = 10'(ahead_sum - 11'(H_TOTAL));
  end

  assign vga.xPos        = h_cnt;
  assign vga.yPos        = v_cnt;
  assign vga.xPosAhead   = ahead;
  assign vga.hSync       = h_sync_q;
  assign vga.fSync       = f_sync_q;
  assign vga.activeVideo = active_q;
  assign vga.frameStart  = start_q;
  assign vga.pixleOutput = pix_q;
  assign vga.flash       = flash_q;

endmodule

// File: tb/tb_vga_scan_timer.sv
// Bench for vga_scan_timer: full-size and shrunken timings
// against an arithmetic raster model.
module tb_vga_scan_timer;

  typedef struct packed {
    logic        hs;
    logic        fs;
    logic [15:0] px;
    logic [9:0]  x;
    logic [9:0]  y;
    logic [9:0]  xa;
    logic        av;
    logic        st;
    logic        fl;
  } obs_t;

  typedef struct {
    int ha, hf, hs, hb;
    int va, vf, vs, vb;
    int pf, ff;
  } cfg_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #20 clk = ~clk;

  vga_scan_if bus_a ();
  vga_scan_if bus_b ();
  vga_scan_if bus_c ();

  vga_scan_timer dut_a (
    .clkVGA (clk),
    .rst_n  (rst_n),
    .vga    (bus_a)
  );

  vga_scan_timer #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(2),
    .PREFETCH(2), .FLASH_FRAMES(4)
  ) dut_b (
    .clkVGA (clk),
    .rst_n  (rst_n),
    .vga    (bus_b)
  );

  vga_scan_timer #(.PREFETCH(3)) dut_c (
    .clkVGA (clk),
    .rst_n  (rst_n),
    .vga    (bus_c)
  );

  cfg_t ca = '{640, 16, 96, 48, 480, 10, 2, 33, 1, 16};
  cfg_t cb = '{8, 2, 3, 3, 4, 1, 2, 2, 2, 4};
  cfg_t cc = '{640, 16, 96, 48, 480, 10, 2, 33, 3, 16};

  obs_t oa, ob, oc;
  assign oa = {bus_a.hSync, bus_a.fSync, bus_a.pixleOutput,
               bus_a.xPos, bus_a.yPos, bus_a.xPosAhead,
               bus_a.activeVideo, bus_a.frameStart, bus_a.flash};
  assign ob = {bus_b.hSync, bus_b.fSync, bus_b.pixleOutput,
               bus_b.xPos, bus_b.yPos, bus_b.xPosAhead,
               bus_b.activeVideo, bus_b.frameStart, bus_b.flash};
  assign oc = {bus_c.hSync, bus_c.fSync, bus_c.pixleOutput,
               bus_c.xPos, bus_c.yPos, bus_c.xPosAhead,
               bus_c.activeVideo, bus_c.frameStart, bus_c.flash};

  int checks = 0;
  int errors = 0;
  int t = 0;
  logic [15:0] pa_prev = '0;
  logic [15:0] pb_prev = '0;
  logic [15:0] pc_prev = '0;

  bit stats_on = 1'b0;
  int hs_low = 0;
  int hs_first_x = -1;
  int av_cnt = 0;
  int fs_low = 0;
  int fs_first_t = -1;
  int xa_a = -1;
  int xa_c = -1;
  logic last_fl = 1'b0;
  int starts[$];
  int toggles[$];

  // Raster state after t edges since reset release,
  // derived from elapsed-time arithmetic.
  function automatic obs_t model(cfg_t c, int tt,
                                 logic [15:0] pp);
    int ht, vt, ft, p, hp, vp;
    obs_t o;
    ht = c.ha + c.hf + c.hs + c.hb;
    vt = c.va + c.vf + c.vs + c.vb;
    ft = ht * vt;
    o.x  = 10'(tt % ht);
    o.y  = 10'((tt / ht) % vt);
    o.xa = 10'(((tt % ht) + c.pf) % ht);
    o.fl = (((tt / ft) / c.ff) % 2) == 1;
    if (tt == 0) begin
      o.hs = 1'b1;
      o.fs = 1'b1;
      o.av = 1'b0;
      o.st = 1'b0;
      o.px = '0;
    end else begin
      p  = tt - 1;
      hp = p % ht;
      vp = (p / ht) % vt;
      o.hs = !(hp >= c.ha + c.hf && hp < c.ha + c.hf + c.hs);
      o.fs = !(vp >= c.va + c.vf && vp < c.va + c.vf + c.vs);
      o.av = (hp < c.ha) && (vp < c.va);
      o.px = o.av ? pp : 16'h0;
      o.st = (p % ft) == 0;
    end
    return o;
  endfunction

  task automatic chk(string tag, int tt,
                     logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s t=%0d observed=%0h expected=%0h",
             tag, tt, obs, exp);
    end
  endtask

  task automatic check_cycle();
    chk("dut_a", t, 64'(oa), 64'(model(ca, t, pa_prev)));
    chk("dut_b", t, 64'(ob), 64'(model(cb, t, pb_prev)));
    chk("dut_c", t, 64'(oc), 64'(model(cc, t, pc_prev)));
    if (stats_on) begin
      if (t >= 1 && t <= 800) begin
        if (!oa.hs) begin
          hs_low++;
          if (hs_first_x < 0) hs_first_x = int'(oa.x);
        end
        if (oa.av) av_cnt++;
      end
      if (t >= 1 && t <= 144 && !ob.fs) begin
        fs_low++;
        if (fs_first_t < 0) fs_first_t = t;
      end
      if (ob.st) starts.push_back(t);
      if (ob.fl !== last_fl) begin
        toggles.push_back(t);
        last_fl = ob.fl;
      end
      if (oa.x == 10'd799) xa_a = int'(oa.xa);
      if (oc.x == 10'd798) xa_c = int'(oc.xa);
    end
    bus_a.pixelValue = {6'b0, 10'(t % 800)};
    bus_b.pixelValue = 16'($urandom);
    bus_c.pixelValue = 16'($urandom);
    pa_prev = bus_a.pixelValue;
    pb_prev = bus_b.pixelValue;
    pc_prev = bus_c.pixelValue;
  endtask

  task automatic run(int n);
    repeat (n) begin
      check_cycle();
      @(negedge clk);
      t++;
    end
  endtask

  task automatic chk_reset(string tag);
    chk({tag, "_a"}, t, 64'(oa), 64'(model(ca, 0, 16'h0)));
    chk({tag, "_b"}, t, 64'(ob), 64'(model(cb, 0, 16'h0)));
    chk({tag, "_c"}, t, 64'(oc), 64'(model(cc, 0, 16'h0)));
  endtask

  initial begin
    bus_a.pixelValue = '0;
    bus_b.pixelValue = '0;
    bus_c.pixelValue = '0;
    repeat (3) @(negedge clk);
    chk_reset("held_reset");
    rst_n = 1'b1;
    t = 0;
    stats_on = 1'b1;
    run(1201);
    stats_on = 1'b0;

    chk("hsync_low_clocks", 0, 64'(hs_low), 64'(96));
    chk("hsync_first_x", 0, 64'(hs_first_x), 64'(657));
    chk("active_clocks", 0, 64'(av_cnt), 64'(640));
    chk("fsync_low_clocks", 0, 64'(fs_low), 64'(32));
    chk("fsync_first_t", 0, 64'(fs_first_t), 64'(81));
    chk("xahead_pf1_799", 0, 64'(xa_a), 64'(0));
    chk("xahead_pf3_798", 0, 64'(xa_c), 64'(1));
    chk("fstart_pulses", 0, 64'(starts.size()), 64'(9));
    foreach (starts[i])
      chk("fstart_time", i, 64'(starts[i]), 64'(1 + 144 * i));
    chk("flash_toggles", 0, 64'(toggles.size()), 64'(2));
    foreach (toggles[i])
      chk("flash_time", i, 64'(toggles[i]),
          64'(576 * (i + 1)));

    while (t % 800 != 300) run(1);
    chk("pre_reset_x", t, 64'(oa.x), 64'(300));
    #5 rst_n = 1'b0;
    #1 chk_reset("async_reset");
    @(negedge clk);
    chk_reset("reset_edge");
    rst_n = 1'b1;
    t = 0;
    run(300);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
